// File: rtl/tanh_grad_pkg.sv
// Shared FP32 field layout, constants and FSM encoding for the tanh gradient backprop block.
package tanh_grad_pkg;

  localparam int FP_W      = 32;
  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int EXP_LSB   = 23;
  localparam int SIGN_BIT  = 31;
  localparam int EXP_BIAS  = 127;

  localparam logic [FP_W-1:0]  FP_ONE  = 32'h3F800000;
  localparam logic [FP_W-1:0]  FP_QNAN = 32'h7FC00000;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SQUARE   = 3'd1,
    SUBTRACT = 3'd2,
    SCALE    = 3'd3,
    DONE     = 3'd4
  } state_e;

  function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] v);
    return v[SIGN_BIT-1:EXP_LSB];
  endfunction

endpackage

// File: rtl/fp32_mul.sv
// Combinational FP32 multiply: truncating, zero/denormal operands and underflow flush to +0.
module fp32_mul
  import tanh_grad_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] p_o
);

  logic [7:0]  ea, eb;
  logic [47:0] prod;
  logic [9:0]  e_sum;
  logic [9:0]  e_res;
  logic [22:0] mant;
  logic        sign;
  logic        unused_prod;

  assign ea   = fp_exp(a_i);
  assign eb   = fp_exp(b_i);
  assign sign = a_i[SIGN_BIT] ^ b_i[SIGN_BIT];
  assign prod = 48'({1'b1, a_i[22:0]}) * 48'({1'b1, b_i[22:0]});
  assign unused_prod = ^prod[22:0];

  always_comb begin
    // Biased sum kept unsigned: results at or below the bias underflow to zero.
    e_sum = {2'b00, ea} + {2'b00, eb} + {9'd0, prod[47]};
    e_res = e_sum - 10'd127;
    mant  = prod[47] ? prod[46:24] : prod[45:23];
    p_o   = '0;
    if (ea == 8'd0 || eb == 8'd0 || e_sum <= 10'd127) begin
      p_o = '0;
    end else if (e_res > 10'd255) begin
      p_o = {sign, EXP_MAX, 23'h7FFFFF};
    end else begin
      p_o = {sign, e_res[7:0], mant};
    end
  end

endmodule

// File: rtl/tanh_grad_backprop.sv
// Serial tanh backward pass dx = g*(1-y*y) over FP32 lanes, one shared multiplier.
// Optional TANH_GRAD_NAN_EN: exponent-255 lanes produce canonical qNaN and set err.
module tanh_grad_backprop
  import tanh_grad_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int No_of_Neurons = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [DATA_WIDTH*No_of_Neurons-1:0] activatedNeurons,
  input  logic [DATA_WIDTH*No_of_Neurons-1:0] gradIn,
  output logic                                busy,
  output logic                                Finished,
  output logic [DATA_WIDTH*No_of_Neurons-1:0] gradOut,
  output logic                                err,
  output logic [2:0]                          dbg_state_o
);

  localparam int N     = No_of_Neurons;
  localparam int VEC_W = DATA_WIDTH * N;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               busy_q, fin_q, err_q;
  logic [VEC_W-1:0]   y_q, g_q, grad_q;
  logic [31:0]        p_q, d_q;

  logic [31:0] y_lane, g_lane, mul_a, mul_b, mul_p, sub_d, scale_res;
  logic        lane_nan;

  assign y_lane = y_q[DATA_WIDTH*idx_q +: DATA_WIDTH];
  assign g_lane = g_q[DATA_WIDTH*idx_q +: DATA_WIDTH];

  // One multiplier: squares y in SQUARE, scales g by d in SCALE.
  assign mul_a = (state_q == SCALE) ? g_lane : y_lane;
  assign mul_b = (state_q == SCALE) ? d_q    : y_lane;

  fp32_mul u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

`ifdef TANH_GRAD_NAN_EN
  assign lane_nan = (fp_exp(y_lane) == EXP_MAX) || (fp_exp(g_lane) == EXP_MAX);
`else
  assign lane_nan = 1'b0;
`endif

  assign scale_res = lane_nan ? FP_QNAN : mul_p;

  // d = 1.0 - p, p aligned to 1.0 with 3 guard bits, renormalised by leading-zero count.
  logic [7:0]  ep, sh;
  logic [26:0] aligned, diff, norm;
  logic [4:0]  lz;
  logic        unused_sub;

  always_comb begin
    ep      = fp_exp(p_q);
    sh      = 8'd127 - ep;
    aligned = {1'b1, p_q[22:0], 3'b000} >> sh;
    diff    = 27'h4000000 - aligned;
    lz      = '0;
    for (int i = 0; i < 27; i++) begin
      if (diff[i]) lz = 5'(26 - i);
    end
    norm  = diff << lz;
    sub_d = '0;
    if (ep == 8'd0) begin
      sub_d = FP_ONE;
    end else if (ep >= 8'd127) begin
      sub_d = '0;
    end else begin
      sub_d = {1'b0, 8'd127 - {3'b000, lz}, norm[25:3]};
    end
  end

  assign unused_sub = ^{p_q[31], norm[26], norm[2:0]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
      y_q     <= '0;
      g_q     <= '0;
      grad_q  <= '0;
      p_q     <= '0;
      d_q     <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          busy_q <= 1'b0;
          fin_q  <= (state_q == DONE);
          if (start) begin
            y_q     <= activatedNeurons;
            g_q     <= gradIn;
            idx_q   <= '0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
            state_q <= SQUARE;
          end
        end
        SQUARE: begin
          busy_q  <= 1'b1;
          p_q     <= mul_p;
          state_q <= SUBTRACT;
        end
        SUBTRACT: begin
          busy_q  <= 1'b1;
          d_q     <= sub_d;
          state_q <= SCALE;
        end
        SCALE: begin
          busy_q <= 1'b1;
          grad_q[DATA_WIDTH*idx_q +: DATA_WIDTH] <= scale_res;
          err_q  <= err_q | lane_nan;
          if (idx_q == IDX_W'(N - 1)) begin
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= SQUARE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign Finished    = fin_q;
  assign err         = err_q;
  assign gradOut     = grad_q;
  assign dbg_state_o = state_q;

endmodule
